// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, owner encoding,
// and the read-tag carried down the latency-matching pipe.
package mem_arb_pkg;

  localparam int LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  // Owner encoding, also used as the tag's is_d bit.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic is_d;
  } tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift register of read tags. The head entry lines up with the
// memory's data_valid for the read that pushed it DEPTH cycles earlier.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = LATENCY_DEF
) (
  input  logic clk,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t head
);

  tag_t pipe [DEPTH];

  // Shift one slot per cycle; clear drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign head = pipe[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache fill FSM and the D-cache fill/write path onto one
// pipelined main memory, holding ownership across locked bursts and steering
// read data back through an in-order tag pipe.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_lock,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              err
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  arb_state_t       state, state_nxt;
  logic             owner;
  logic             rr_last;   // port granted most recently
  logic [CNT_W-1:0] blank_cnt;
  logic             blank;
  logic             fwd;
  tag_t             tag_in, head;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: stay with the owner while its lock is high; from IDLE a
  // locked port only takes ownership on the edge where it is granted.
  always_comb begin
    state_nxt = IDLE;
    if (owner == OWNER_I) begin
      if (i_lock && (state == OWN_I || i_gnt)) state_nxt = OWN_I;
    end else begin
      if (d_lock && (state == OWN_D || d_gnt)) state_nxt = OWN_D;
    end
  end

  // Outputs: pick the owner, forward its request to memory, stall the other.
  // Nothing is issued while reset is held so no tag can be lost.
  always_comb begin
    owner     = OWNER_I;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      OWN_I:   owner = OWNER_I;
      OWN_D:   owner = OWNER_D;
      default: begin
        if (i_req && d_req) owner = ~rr_last;
        else if (d_req)     owner = OWNER_D;
      end
    endcase
    if (rst_n) begin
      if (owner == OWNER_D) begin
        d_gnt  = d_req;
        mem_en = d_req;
        if (d_req) begin
          mem_wr    = d_wr;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end
      end else begin
        i_gnt  = i_req;
        mem_en = i_req;
        if (i_req) begin
          mem_wr    = i_wr;
          mem_addr  = i_addr;
          mem_wdata = i_wdata;
        end
      end
    end
  end

  // Round-robin memory: remember who got the last grant; reset favours D.
  always_ff @(posedge clk) begin
    if (!rst_n)      rr_last <= OWNER_I;
    else if (mem_en) rr_last <= owner;
  end

  // Only reads leave a tag; is_d records the issuer for response routing.
  assign tag_in = '{valid: mem_en & ~mem_wr, is_d: owner};

  arb_tag_pipe #(.DEPTH(LATENCY)) u_tag_pipe (
    .clk    (clk),
    .clr    (~rst_n),
    .tag_in (tag_in),
    .head   (head)
  );

  // Blanking window after reset: reads issued before reset may still return.
  always_ff @(posedge clk) begin
    if (!rst_n)                blank_cnt <= CNT_W'(LATENCY);
    else if (blank_cnt != '0)  blank_cnt <= blank_cnt - CNT_W'(1);
  end

  assign blank = ~rst_n | (blank_cnt != '0);

  // Sticky protocol error: memory data_valid disagrees with the tag pipe.
  always_ff @(posedge clk) begin
    if (!rst_n)                                  err <= 1'b0;
    else if (!blank && (mem_rvalid != head.valid)) err <= 1'b1;
  end

  // Response steering depends only on the tag head, never on the owner.
  assign fwd      = ~blank & mem_rvalid & head.valid;
  assign i_rvalid = fwd & ~head.is_d;
  assign d_rvalid = fwd &  head.is_d;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model and a
// queue-based response scoreboard checked by an independent monitor.
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_wr, i_lock, d_req, d_wr, d_lock;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_en, mem_wr, mem_rvalid, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        inject;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_d;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata), .i_lock(i_lock),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .err(err)
  );

  // Memory contents: 0x0010 holds 0xBEEF, every other word is addr+0x1000.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : a + 16'h1000;
  endfunction

  // Fixed-latency memory: a read accepted in cycle c returns in cycle c+LAT.
  logic [LAT-1:0] rd_v = '0;
  logic [15:0]    rd_a [LAT];
  always @(posedge clk) begin
    rd_v     <= {rd_v[LAT-2:0], mem_en & ~mem_wr};
    rd_a[0]  <= mem_addr;
    for (int k = 1; k < LAT; k++) rd_a[k] <= rd_a[k-1];
  end
  assign mem_rvalid = rd_v[LAT-1] | inject;
  assign mem_rdata  = rd_v[LAT-1] ? mem_word(rd_a[LAT-1]) : 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [15:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  // Response monitor: every rvalid pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (i_rvalid || d_rvalid) begin
      vectors++;
      if (i_rvalid && d_rvalid) begin
        miscompares++;
        $display("FAIL resp both ports: i_rvalid=1 d_rvalid=1, expected one");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp unexpected: port %s data %0h, expected none",
                 d_rvalid ? "D" : "I", d_rvalid ? d_rdata : i_rdata);
      end else begin
        e = exp_q.pop_front();
        if (e.is_d !== d_rvalid || e.data !== (d_rvalid ? d_rdata : i_rdata)) begin
          miscompares++;
          $display("FAIL resp route: got port %s data %0h, expected port %s data %0h",
                   d_rvalid ? "D" : "I", d_rvalid ? d_rdata : i_rdata,
                   e.is_d ? "D" : "I", e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; inject = 1'b0;
    i_req = 0; i_wr = 0; i_lock = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_wr = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset i_gnt", i_gnt, 0);
    chk("reset d_gnt", d_gnt, 0);
    chk("reset mem_en", mem_en, 0);
    chk("reset mem_wr", mem_wr, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset rvalid", {i_rvalid, d_rvalid}, 0);
    chk("reset rdata", {i_rdata, d_rdata}, 0);
    chk("reset err", err, 0);
    idle(6);

    // Single I read of 0x0010.
    i_req = 1; i_addr = 16'h0010;
    @(negedge clk);
    chk("t1 i_gnt", i_gnt, 1);
    chk("t1 d_gnt", d_gnt, 0);
    chk("t1 mem_en", mem_en, 1);
    chk("t1 mem_wr", mem_wr, 0);
    chk("t1 mem_addr", mem_addr, 16'h0010);
    push_exp(1'b0, 16'hBEEF);
    cyc(); i_req = 0; i_addr = '0;
    cyc(); cyc();
    @(negedge clk);
    chk("t1 early i_rvalid", i_rvalid, 0);
    chk("t1 early i_rdata", i_rdata, 0);
    cyc();
    @(negedge clk);
    chk("t1 c4 i_rvalid", i_rvalid, 1);
    chk("t1 c4 i_rdata", i_rdata, 16'hBEEF);
    chk("t1 c4 d_rvalid", d_rvalid, 0);
    idle(5);

    // Both ports request from reset, unlocked: D, I, D, I.
    i_req = 1; i_addr = 16'h0020; d_req = 1; d_addr = 16'h0030; rst_n = 0;
    @(negedge clk);
    chk("t2 reset gnt", {i_gnt, d_gnt}, 0);
    cyc(); cyc();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2 d_gnt", d_gnt, (k % 2 == 0) ? 1 : 0);
      chk("t2 i_gnt", i_gnt, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 0) push_exp(1'b1, 16'h1030);
      else            push_exp(1'b0, 16'h1020);
      cyc();
    end
    i_req = 0; d_req = 0;
    idle(8);

    // D locked 8-read burst while I waits.
    i_req = 1; i_addr = 16'h0040;
    for (int k = 0; k < 8; k++) begin
      d_req = 1; d_addr = 16'(16'h0100 + 2 * k); d_lock = (k < 7);
      @(negedge clk);
      chk("t3 d_gnt", d_gnt, 1);
      chk("t3 i_gnt", i_gnt, 0);
      chk("t3 mem_addr", mem_addr, 16'h0100 + 2 * k);
      push_exp(1'b1, 16'(16'h1100 + 2 * k));
      cyc();
    end
    d_req = 0; d_lock = 0; d_addr = '0;
    @(negedge clk);
    chk("t3 i_gnt after unlock", i_gnt, 1);
    chk("t3 i mem_addr", mem_addr, 16'h0040);
    push_exp(1'b0, 16'h1040);
    cyc(); i_req = 0;
    idle(8);

    // D write: no tag, no response.
    d_req = 1; d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    @(negedge clk);
    chk("t4 d_gnt", d_gnt, 1);
    chk("t4 mem_en", mem_en, 1);
    chk("t4 mem_wr", mem_wr, 1);
    chk("t4 mem_addr", mem_addr, 16'h0200);
    chk("t4 mem_wdata", mem_wdata, 16'h1234);
    cyc(); d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("t4 rvalid", {i_rvalid, d_rvalid}, 0);
    chk("t4 err", err, 0);
    idle(4);

    // I locked burst with D pending; then rr favours I on the next tie.
    d_req = 1; d_addr = 16'h0400;
    for (int k = 0; k < 4; k++) begin
      i_req = 1; i_lock = (k < 3); i_addr = 16'(16'h0300 + 2 * k);
      @(negedge clk);
      chk("t6 i_gnt", i_gnt, 1);
      chk("t6 d_gnt", d_gnt, 0);
      push_exp(1'b0, 16'(16'h1300 + 2 * k));
      cyc();
    end
    i_req = 0; i_lock = 0; i_addr = '0;
    @(negedge clk);
    chk("t6 d_gnt after unlock", d_gnt, 1);
    chk("t6 i_gnt after unlock", i_gnt, 0);
    push_exp(1'b1, 16'h1400);
    cyc(); i_req = 1; i_addr = 16'h0500; d_addr = 16'h0600;
    @(negedge clk);
    chk("t6 tie i_gnt", i_gnt, 1);
    chk("t6 tie d_gnt", d_gnt, 0);
    push_exp(1'b0, 16'h1500);
    cyc(); i_req = 0; i_addr = '0;
    @(negedge clk);
    chk("t6 lone d_gnt", d_gnt, 1);
    push_exp(1'b1, 16'h1600);
    cyc(); d_req = 0; d_addr = '0;
    idle(8);
    @(negedge clk);
    chk("t6 err", err, 0);

    // Reset during a D burst: strays blanked, later unsolicited pulse sets err.
    cyc();
    d_req = 1; d_lock = 1; d_addr = 16'h0700;
    @(negedge clk);
    chk("t5 d_gnt", d_gnt, 1);
    cyc(); d_addr = 16'h0702;
    cyc(); d_addr = 16'h0704; rst_n = 0;
    @(negedge clk);
    chk("t5 reset d_gnt", d_gnt, 0);
    chk("t5 reset mem_en", mem_en, 0);
    cyc(); rst_n = 1; d_req = 0; d_lock = 0; d_addr = '0;
    for (int k = 3; k < 8; k++) begin
      @(negedge clk);
      chk("t5 blank rvalid", {i_rvalid, d_rvalid}, 0);
      chk("t5 blank err", err, 0);
      cyc();
    end
    inject = 1;
    @(negedge clk);
    chk("t5 inject rvalid", {i_rvalid, d_rvalid}, 0);
    cyc(); inject = 0;
    @(negedge clk);
    chk("t5 err set", err, 1);
    idle(3);
    @(negedge clk);
    chk("t5 err sticky", err, 1);
    cyc(); rst_n = 0;
    cyc(); rst_n = 1;
    @(negedge clk);
    chk("t5 err cleared", err, 0);
    idle(6);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
